// File: rtl/cardinal_dmem_arbiter.sv
// Shared data-memory arbiter for multi-node Cardinal builds: one grant per cycle
// (round-robin or fixed priority), with read returns routed back to the issuing node.
module cardinal_dmem_arbiter #(
  parameter int NUM_NODES  = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_NODES-1:0]          Node_MemEn,
  input  logic [NUM_NODES-1:0]          Node_MemWrEn,
  input  logic [NUM_NODES*ADDR_W-1:0]   Node_Addr,
  input  logic [NUM_NODES*DATA_W-1:0]   Node_WrData,
  output logic [NUM_NODES*DATA_W-1:0]   Node_RdData,
  output logic [NUM_NODES-1:0]          Node_RdValid,
  output logic [NUM_NODES-1:0]          Node_Stall,
  output logic                          Mem_En,
  output logic                          Mem_WrEn,
  output logic [ADDR_W-1:0]             Mem_Addr,
  output logic [DATA_W-1:0]             Mem_WrData,
  input  logic [DATA_W-1:0]             Mem_RdData
);

  localparam int ID_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      scan_start;
  logic [ID_W-1:0]      scan_idx;
  logic [ID_W-1:0]      gnt_id;
  logic                 gnt_any;
  logic [NUM_NODES-1:0] grant;
  logic                 rd_issue;
  logic [RD_LAT-1:0]    vld_p;
  logic [ID_W-1:0]      id_p [RD_LAT];
  logic [ID_W-1:0]      ret_id;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_NODES) s = s - NUM_NODES;
    return ID_W'(s);
  endfunction

  // Arbitration: scan from the start point, first requester wins; reset masks all requests
  always_comb begin
    scan_start = (FIXED_PRIO != 0) ? '0 : rr_ptr;
    scan_idx   = '0;
    gnt_id     = '0;
    gnt_any    = 1'b0;
    for (int k = 0; k < NUM_NODES; k++) begin
      scan_idx = wrap_idx(scan_start, k);
      if (Reset && !gnt_any && Node_MemEn[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  assign Node_Stall = Node_MemEn & ~grant & {NUM_NODES{Reset}};

  always_comb begin
    Mem_En     = gnt_any;
    Mem_WrEn   = 1'b0;
    Mem_Addr   = '0;
    Mem_WrData = '0;
    if (gnt_any) begin
      Mem_WrEn   = Node_MemWrEn[gnt_id];
      Mem_Addr   = Node_Addr[int'(gnt_id)*ADDR_W +: ADDR_W];
      Mem_WrData = Node_WrData[int'(gnt_id)*DATA_W +: DATA_W];
    end
  end

  assign rd_issue = gnt_any & ~Mem_WrEn;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rr_ptr <= '0;
    end else if (gnt_any && (FIXED_PRIO == 0)) begin
      rr_ptr <= (gnt_id == ID_W'(NUM_NODES - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  // Read pipeline p0..p(RD_LAT-1): tracks which node owns the data the dmem is producing
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_issue;
      for (int s = 1; s < RD_LAT; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge Clock) begin
    id_p[0] <= gnt_id;
    for (int s = 1; s < RD_LAT; s++) id_p[s] <= id_p[s-1];
  end

  assign ret_id = id_p[RD_LAT-1];

  // Return stage: capture dmem data into the owning lane, pulse its valid for one cycle
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Node_RdValid <= '0;
      Node_RdData  <= '0;
    end else begin
      Node_RdValid <= '0;
      if (vld_p[RD_LAT-1]) begin
        Node_RdValid[ret_id]                         <= 1'b1;
        Node_RdData[int'(ret_id)*DATA_W +: DATA_W]   <= Mem_RdData;
      end
    end
  end

endmodule

// File: tb/tb_cardinal_dmem_arbiter.sv
// Bench for cardinal_dmem_arbiter: a round-robin RD_LAT=1 unit and a fixed-priority
// RD_LAT=3 unit, each checked every cycle against a behavioural arbiter/memory model.
module tb_cardinal_dmem_arbiter;
  localparam int N    = 4;
  localparam int AW   = 8;
  localparam int DW   = 64;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [N-1:0]    en [2];
  logic [N-1:0]    we [2];
  logic [N*AW-1:0] addr [2];
  logic [N*DW-1:0] wd [2];
  logic [N*DW-1:0] rdd [2];
  logic [N-1:0]    rdv [2];
  logic [N-1:0]    stall [2];
  logic            m_en [2];
  logic            m_we [2];
  logic [AW-1:0]   m_addr [2];
  logic [DW-1:0]   m_wd [2];
  logic [DW-1:0]   m_rd [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  cardinal_dmem_arbiter #(.NUM_NODES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT0), .FIXED_PRIO(0)) dut0 (
    .Clock(clk), .Reset(rst_n), .Node_MemEn(en[0]), .Node_MemWrEn(we[0]), .Node_Addr(addr[0]),
    .Node_WrData(wd[0]), .Node_RdData(rdd[0]), .Node_RdValid(rdv[0]), .Node_Stall(stall[0]),
    .Mem_En(m_en[0]), .Mem_WrEn(m_we[0]), .Mem_Addr(m_addr[0]), .Mem_WrData(m_wd[0]), .Mem_RdData(m_rd[0]));

  cardinal_dmem_arbiter #(.NUM_NODES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT1), .FIXED_PRIO(1)) dut1 (
    .Clock(clk), .Reset(rst_n), .Node_MemEn(en[1]), .Node_MemWrEn(we[1]), .Node_Addr(addr[1]),
    .Node_WrData(wd[1]), .Node_RdData(rdd[1]), .Node_RdValid(rdv[1]), .Node_Stall(stall[1]),
    .Mem_En(m_en[1]), .Mem_WrEn(m_we[1]), .Mem_Addr(m_addr[1]), .Mem_WrData(m_wd[1]), .Mem_RdData(m_rd[1]));

  function automatic int lat_of(int c);
    return (c == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit fixed_of(int c);
    return c == 1;
  endfunction

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    if (a == 8'h10) return 64'hDEADBEEF00000001;
    return {24'hC0FFEE, a, 32'(a) * 32'h9E3779B9};
  endfunction

  // Shared dmem stand-ins: write commits at the edge, read data appears RD_LAT cycles later
  logic [DW-1:0] bmem [2][256];
  bit            bwr  [2][256];
  logic [DW-1:0] line [2][4];

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      for (int k = 3; k > 0; k--) line[c][k] <= line[c][k-1];
      if (m_en[c] && !m_we[c])
        line[c][0] <= bwr[c][m_addr[c]] ? bmem[c][m_addr[c]] : init_word(m_addr[c]);
      else
        line[c][0] <= {2{32'hBADC0DE5}};
      if (m_en[c] && m_we[c]) begin
        bmem[c][m_addr[c]] <= m_wd[c];
        bwr[c][m_addr[c]]  <= 1'b1;
      end
    end
  end

  assign m_rd[0] = line[0][LAT0-1];
  assign m_rd[1] = line[1][LAT1-1];

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: arbitration by distance from pointer, memory and returns as timestamped slots
  int            ptr [2];
  logic [N-1:0]  last_grant [2];
  logic [DW-1:0] mmem [2][256];
  bit            mwr [2][256];
  logic [DW-1:0] exp_rdd [2][N];
  bit            pend_v [2][8];
  int            pend_node [2][8];
  logic [DW-1:0] pend_data [2][8];

  task automatic model_and_check(int c);
    int g, best, slot;
    logic [N-1:0] gv, rdv_e, st_e;
    logic [N*DW-1:0] rdd_e;
    logic e_en, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    string p;
    p = $sformatf("u%0d", c);
    g = -1;
    rdv_e = '0;
    if (!rst_n) begin
      ptr[c] = 0;
      for (int s = 0; s < 8; s++) pend_v[c][s] = 0;
      for (int i = 0; i < N; i++) exp_rdd[c][i] = '0;
    end else begin
      slot = cyc % 8;
      if (pend_v[c][slot]) begin
        exp_rdd[c][pend_node[c][slot]] = pend_data[c][slot];
        rdv_e[pend_node[c][slot]] = 1'b1;
        pend_v[c][slot] = 0;
      end
      best = N;
      for (int i = 0; i < N; i++) begin
        if (en[c][i]) begin
          int d;
          d = fixed_of(c) ? i : (i - ptr[c] + N) % N;
          if (d < best) begin
            best = d;
            g = i;
          end
        end
      end
    end
    gv = '0; e_en = 1'b0; e_we = 1'b0; e_a = '0; e_d = '0;
    if (g >= 0) begin
      gv[g] = 1'b1;
      e_en = 1'b1;
      e_we = we[c][g];
      e_a  = addr[c][g*AW +: AW];
      e_d  = wd[c][g*DW +: DW];
    end
    st_e = rst_n ? (en[c] & ~gv) : '0;
    for (int i = 0; i < N; i++) rdd_e[i*DW +: DW] = exp_rdd[c][i];
    chk({p, ".mem_en"},  256'(m_en[c]),   256'(e_en));
    chk({p, ".mem_we"},  256'(m_we[c]),   256'(e_we));
    chk({p, ".mem_addr"}, 256'(m_addr[c]), 256'(e_a));
    chk({p, ".mem_wd"},  256'(m_wd[c]),   256'(e_d));
    chk({p, ".stall"},   256'(stall[c]),  256'(st_e));
    chk({p, ".rdvalid"}, 256'(rdv[c]),    256'(rdv_e));
    chk({p, ".rddata"},  256'(rdd[c]),    256'(rdd_e));
    if (g >= 0) begin
      if (e_we) begin
        mmem[c][e_a] = e_d;
        mwr[c][e_a]  = 1'b1;
      end else begin
        slot = (cyc + lat_of(c) + 1) % 8;
        pend_v[c][slot]    = 1'b1;
        pend_node[c][slot] = g;
        pend_data[c][slot] = mwr[c][e_a] ? mmem[c][e_a] : init_word(e_a);
      end
      if (!fixed_of(c)) ptr[c] = (g + 1) % N;
    end
    last_grant[c] = gv;
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) model_and_check(c);
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic req(int c, int n, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    en[c][n] = 1'b1;
    we[c][n] = w;
    addr[c][n*AW +: AW] = a;
    wd[c][n*DW +: DW] = d;
  endtask

  task automatic req2(int n, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    req(0, n, w, a, d);
    req(1, n, w, a, d);
  endtask

  task automatic drop(int n);
    en[0][n] = 1'b0;
    en[1][n] = 1'b0;
  endtask

  task automatic idle();
    for (int c = 0; c < 2; c++) begin
      en[c] = '0; we[c] = '0; addr[c] = '0; wd[c] = '0;
    end
  endtask

  initial begin
    logic [N-1:0] sm;
    int dens;
    idle();
    for (int c = 0; c < 2; c++) en[c] = '1;
    #1 rst_n = 1'b0;

    // Reset holds everything quiet even with all nodes requesting
    repeat (2) sample();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("u%0d.rst_mem_en", c), 256'(m_en[c]), 256'(0));
      chk($sformatf("u%0d.rst_stall", c), 256'(stall[c]), 256'(0));
      chk($sformatf("u%0d.rst_rdv", c), 256'(rdv[c]), 256'(0));
      chk($sformatf("u%0d.rst_rdd", c), 256'(rdd[c]), 256'(0));
    end
    step(); rst_n = 1'b1; idle();

    // Single requester: node 2 reads 0x10
    step(); req2(2, 1'b0, 8'h10, '0);
    sample();
    chk("u0.single_mem_en", 256'(m_en[0]), 256'(1));
    chk("u0.single_addr", 256'(m_addr[0]), 256'(8'h10));
    chk("u0.single_stall", 256'(stall[0]), 256'(0));
    step(); drop(2);
    sample();
    sample();
    chk("u0.single_rdv", 256'(rdv[0]), 256'(4'b0100));
    chk("u0.single_lane2", 256'(rdd[0][2*DW +: DW]), 256'(64'hDEADBEEF00000001));
    sample();
    sample();
    chk("u1.single_rdv", 256'(rdv[1]), 256'(4'b0100));
    chk("u1.single_lane2", 256'(rdd[1][2*DW +: DW]), 256'(64'hDEADBEEF00000001));

    // Round-robin contention from pointer 0
    step(); rst_n = 1'b0; idle();
    sample();
    step(); rst_n = 1'b1;
    for (int i = 0; i < N; i++) req2(i, 1'b0, 8'(8'h20 + i), '0);
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        step(); drop(k - 1);
      end
      sample();
      sm = 4'b1110 << k;
      chk($sformatf("u0.rr_addr%0d", k), 256'(m_addr[0]), 256'(8'(8'h20 + k)));
      chk($sformatf("u0.rr_stall%0d", k), 256'(stall[0]), 256'(sm));
    end
    step(); drop(3); req2(0, 1'b0, 8'h30, '0); req2(1, 1'b0, 8'h31, '0);
    sample();
    chk("u0.rr_wrap_addr", 256'(m_addr[0]), 256'(8'h30));
    step(); drop(0);
    sample();
    step(); idle();

    // Fixed priority: node 0 starves node 3 until it drops out
    step(); req2(0, 1'b0, 8'h40, '0); req2(3, 1'b0, 8'h43, '0);
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("u1.fp_stall%0d", k), 256'(stall[1]), 256'(4'b1000));
      chk($sformatf("u1.fp_addr%0d", k), 256'(m_addr[1]), 256'(8'h40));
      step();
    end
    drop(0);
    sample();
    chk("u1.fp_switch_addr", 256'(m_addr[1]), 256'(8'h43));
    chk("u1.fp_switch_stall", 256'(stall[1]), 256'(0));
    step(); idle();

    // Write then read of the same address on consecutive cycles
    step(); req2(1, 1'b1, 8'h05, 64'h0123456789ABCDEF);
    step(); drop(1); req2(0, 1'b0, 8'h05, '0);
    step(); drop(0);
    sample();
    sample();
    chk("u0.raw_rdv", 256'(rdv[0]), 256'(4'b0001));
    chk("u0.raw_lane0", 256'(rdd[0][0 +: DW]), 256'(64'h0123456789ABCDEF));
    sample();
    sample();
    chk("u1.raw_rdv", 256'(rdv[1]), 256'(4'b0001));
    chk("u1.raw_lane0", 256'(rdd[1][0 +: DW]), 256'(64'h0123456789ABCDEF));

    // Reset one cycle after a read grant discards the read
    step(); req2(1, 1'b0, 8'h10, '0);
    step(); drop(1); rst_n = 1'b0;
    step();
    step(); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk($sformatf("u1.rstrd_rdv%0d", k), 256'(rdv[1][1]), 256'(0));
      chk($sformatf("u0.rstrd_rdv%0d", k), 256'(rdv[0][1]), 256'(0));
    end
    chk("u1.rstrd_lane1", 256'(rdd[1][DW +: DW]), 256'(0));
    chk("u0.rstrd_lane1", 256'(rdd[0][DW +: DW]), 256'(0));

    // Random traffic: stalled requests held, new ones drawn at varying density
    for (int k = 0; k < 4000; k++) begin
      step();
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      dens = (k < 1000) ? 25 : (k < 2000) ? 60 : (k < 3000) ? 90 : 100;
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < N; i++) begin
          if (!(en[c][i] && !last_grant[c][i])) begin
            if ($urandom_range(0, 99) < dens)
              req(c, i, ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 15)), {$urandom, $urandom});
            else
              en[c][i] = 1'b0;
          end
        end
      end
    end
    step(); rst_n = 1'b1; idle();
    repeat (6) sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cardinal_dmem_arbiter.md
Name: cardinal_dmem_arbiter

Overview:
Parametrised N-node shared data-memory arbiter for multi-node Cardinal processor builds. Each node keeps its existing single-node dmem interface (enable, write-enable, 8-bit address, 64-bit data) and gains a stall output. The arbiter grants one request per cycle to a single shared dmem, pipelines read returns back to the issuing node, and supports round-robin or fixed-priority arbitration.

Parameters:
NUM_NODES, 4, number of processor nodes (2..8)
ADDR_W, 8, memory address width
DATA_W, 64, data word width
RD_LAT, 1, shared dmem read latency in clocks (1..4)
FIXED_PRIO, 0, 0 = round-robin, 1 = fixed priority with node 0 highest

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-low reset; asserted when 0
Node_MemEn  in  NUM_NODES  per-node memory request
Node_MemWrEn  in  NUM_NODES  per-node write qualifier, 1 = write, 0 = read
Node_Addr  in  NUM_NODES*ADDR_W  per-node address, node i at slice [i*ADDR_W +: ADDR_W]
Node_WrData  in  NUM_NODES*DATA_W  per-node write data
Node_RdData  out  NUM_NODES*DATA_W  per-node registered read data
Node_RdValid  out  NUM_NODES  one-cycle pulse, read data valid
Node_Stall  out  NUM_NODES  request pending and not granted this cycle
Mem_En  out  1  shared dmem enable
Mem_WrEn  out  1  shared dmem write enable
Mem_Addr  out  ADDR_W  shared dmem address
Mem_WrData  out  DATA_W  shared dmem write data
Mem_RdData  in  DATA_W  shared dmem read data

Behaviour:
- Reset (0): Node_RdData = 0, Node_RdValid = 0, round-robin pointer = 0, read pipeline flushed. Mem_En, Mem_WrEn and Node_Stall are forced to 0 while reset is asserted, and all requests are ignored.
- Arbitration is combinational within a cycle, with at most one grant per cycle.
- Round-robin: search starts at the pointer and wraps modulo NUM_NODES. On any grant, the pointer becomes granted+1 mod NUM_NODES. With no grant, the pointer holds.
- Fixed priority: the lowest requesting index wins, and the pointer is unused.
- Node_Stall[i] = Node_MemEn[i] & ~grant[i]. A stalled node holds its request, address and data stable until the cycle it is granted. The arbiter does not queue requests.
- Memory side: Mem_En = any grant. Mem_WrEn, Mem_Addr and Mem_WrData are muxed combinationally from the granted node. With no grant, all memory outputs are 0.
- Write granted in cycle T: dmem commits at the rising edge that ends T. There is no response and no RdValid.
- Read granted in cycle T: the node id is pushed into an RD_LAT-deep valid/id shift pipeline.
  - Mem_RdData is valid in cycle T+RD_LAT and is sampled at the edge that ends that cycle.
  - Node_RdData[id] and Node_RdValid[id] = 1 are valid in cycle T+RD_LAT+1, so total read latency is RD_LAT+1 cycles.
  - Node_RdValid is a single-cycle pulse. Node_RdData holds its value until the next read to the same node.
- Back-to-back reads are fully pipelined, one per cycle. Each node may have multiple reads in flight, and returns arrive in grant order.
- A write granted in cycle T followed by a read to the same address granted in T+1 (any node) returns the new data.
- Only the granted node's Node_RdData lane changes. Other lanes hold.
- Reset asserted mid-operation: in-flight reads are discarded immediately, with no RdValid pulse after reset release.
- A single requester is never stalled.
- Starvation bound in round-robin mode: a continuously requesting node is granted within NUM_NODES cycles.

Test Plan:
- Reset: hold Reset=0 with all Node_MemEn=1 -> Mem_En=0, all Stall=0, all RdValid=0, all RdData=0.
- Single node, no contention: node 2 reads addr 8'h10 (mem = 64'hDEADBEEF00000001), RD_LAT=1 -> Mem_En=1 in T; Node_RdValid[2]=1 and lane 2 = 64'hDEADBEEF00000001 in T+2; Stall[2]=0 throughout.
- Round-robin contention: all 4 nodes request in T with pointer=0 -> grants 0,1,2,3 in T..T+3; Stall counts 0,1,2,3 cycles respectively; pointer returns to 0.
- Fixed priority (FIXED_PRIO=1): nodes 0 and 3 request continuously -> node 0 granted every cycle and Stall[3] stays 1; node 0 drops its request -> node 3 granted the next cycle.
- Write then read: node 1 writes 64'h0123456789ABCDEF to addr 8'h05 in T; node 0 reads 8'h05 in T+1 -> node 0 receives 64'h0123456789ABCDEF with RdValid[0] in T+1+RD_LAT+1.
- Reset mid-read: RD_LAT=3, node 1 read granted, Reset=0 one cycle later for 2 cycles -> no RdValid[1] ever; lane 1 = 0.
